// File: rtl/painterengine_gpu_reader_arbiter.sv
// Four-way arbiter and job controller for the GPU DMA reader.
// Define PAINTERENGINE_GPU_READER_ARBITER_RR_EN for round-robin; default is fixed priority (0 highest).
module painterengine_gpu_reader_arbiter #(
  parameter int TIMEOUT_W = 20
) (
  input  logic             i_wire_clock,
  input  logic             i_wire_reset,
  input  logic [3:0]       i_wire_req,
  input  logic [3:0][31:0] i_wire_address,
  input  logic [3:0][31:0] i_wire_length,
  output logic [3:0]       o_wire_grant,
  output logic [3:0]       o_wire_done,
  output logic [3:0]       o_wire_error,
  output logic [2:0]       o_wire_error_type,
  output logic             o_wire_reader_resetn,
  output logic [3:0]       o_wire_reader_router,
  output logic [3:0][31:0] o_wire_reader_address,
  output logic [3:0][31:0] o_wire_reader_length,
  input  logic             i_wire_reader_done,
  input  logic             i_wire_reader_error,
  input  logic [2:0]       i_wire_reader_error_type
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_FINISH} state_t;

  state_t               r_state;
  logic [3:0]           r_grant;
  logic [3:0]           r_done;
  logic [3:0]           r_error;
  logic [2:0]           r_error_type;
  logic                 r_resetn;
  logic [3:0][31:0]     r_addr;
  logic [3:0][31:0]     r_len;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [TIMEOUT_W-1:0] w_wd_inc;
  logic [1:0]           w_win_idx;
  logic [3:0]           w_win;

`ifdef PAINTERENGINE_GPU_READER_ARBITER_RR_EN
  logic [1:0] r_ptr;
  logic       w_found;

  // Search starts at the pointer; 2-bit index arithmetic gives the 3->0 wrap.
  always_comb begin
    w_win_idx = r_ptr;
    w_found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && i_wire_req[r_ptr + 2'(i)]) begin
        w_found   = 1'b1;
        w_win_idx = r_ptr + 2'(i);
      end
    end
  end
`else
  always_comb begin
    w_win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i_wire_req[i]) w_win_idx = 2'(i);
    end
  end
`endif

  assign w_win    = 4'b0001 << w_win_idx;
  assign w_wd_inc = r_wd + TIMEOUT_W'(1);

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_done       <= '0;
      r_error      <= '0;
      r_error_type <= '0;
      r_resetn     <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_wd         <= '0;
`ifdef PAINTERENGINE_GPU_READER_ARBITER_RR_EN
      r_ptr        <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resetn <= 1'b0;
          if (|i_wire_req) begin
            r_grant <= w_win;
            for (int s = 0; s < 4; s++) begin
              r_addr[s] <= w_win[s] ? i_wire_address[s] : 32'd0;
              r_len[s]  <= w_win[s] ? i_wire_length[s]  : 32'd0;
            end
            r_wd    <= '0;
`ifdef PAINTERENGINE_GPU_READER_ARBITER_RR_EN
            r_ptr   <= w_win_idx + 2'd1;
`endif
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_resetn <= 1'b1;
          r_state  <= S_BUSY;
        end
        S_BUSY: begin
          r_wd <= w_wd_inc;
          if (i_wire_reader_error) begin
            r_error_type <= i_wire_reader_error_type;
            r_error      <= r_grant;
            r_resetn     <= 1'b0;
            r_state      <= S_FINISH;
          end else if (i_wire_reader_done) begin
            r_done   <= r_grant;
            r_resetn <= 1'b0;
            r_state  <= S_FINISH;
          end else if (w_wd_inc[TIMEOUT_W-1]) begin
            // Abort on the cycle the MSB would set: BUSY lasts 2^(TIMEOUT_W-1) cycles.
            r_error_type <= 3'b110;
            r_error      <= r_grant;
            r_resetn     <= 1'b0;
            r_state      <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_done   <= '0;
          r_error  <= '0;
          r_grant  <= '0;
          r_addr   <= '0;
          r_len    <= '0;
          r_resetn <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wire_grant          = r_grant;
  assign o_wire_reader_router  = r_grant;
  assign o_wire_done           = r_done;
  assign o_wire_error          = r_error;
  assign o_wire_error_type     = r_error_type;
  assign o_wire_reader_resetn  = r_resetn;
  assign o_wire_reader_address = r_addr;
  assign o_wire_reader_length  = r_len;

endmodule

// File: tb/tb_painterengine_gpu_reader_arbiter.sv
// Randomized self-checking bench for painterengine_gpu_reader_arbiter (TIMEOUT_W=6).
module tb_painterengine_gpu_reader_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [3:0][31:0] addr, len;
  logic [3:0]       o_grant, o_done, o_error, o_router;
  logic [2:0]       o_et;
  logic             o_resetn;
  logic [3:0][31:0] o_addr, o_len;
  logic             rd_done, rd_err;
  logic [2:0]       rd_et;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_ptr;
  logic [2:0] m_etype;

  typedef struct {
    logic [3:0]       g, r, pd, pe, g_end;
    int               np, busy, glat, rlat;
    logic [3:0][31:0] sa, sl;
    bit               to, hold;
  } obs_t;

  painterengine_gpu_reader_arbiter #(.TIMEOUT_W(6)) dut (
    .i_wire_clock            (clk),
    .i_wire_reset            (rst),
    .i_wire_req              (req),
    .i_wire_address          (addr),
    .i_wire_length           (len),
    .o_wire_grant            (o_grant),
    .o_wire_done             (o_done),
    .o_wire_error            (o_error),
    .o_wire_error_type       (o_et),
    .o_wire_reader_resetn    (o_resetn),
    .o_wire_reader_router    (o_router),
    .o_wire_reader_address   (o_addr),
    .o_wire_reader_length    (o_len),
    .i_wire_reader_done      (rd_done),
    .i_wire_reader_error     (rd_err),
    .i_wire_reader_error_type(rd_et)
  );

  always #5 clk = ~clk;

  // Reference arbitration: first requesting index from the pointer (RR) or from 0 (fixed).
  function automatic int model_winner(logic [3:0] r, int ptr);
`ifdef PAINTERENGINE_GPU_READER_ARBITER_RR_EN
    for (int i = 0; i < 4; i++) if (r[(ptr + i) % 4]) return (ptr + i) % 4;
`else
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`endif
    return -1;
  endfunction

  // Plays the reader for one job: done/error asserted so the DUT samples it on BUSY cycle lat (0 = never).
  task automatic serve(input int lat, input bit err, input bit both, input logic [2:0] et, output obs_t o);
    int n;
    o.g = '0; o.r = '0; o.pd = '0; o.pe = '0; o.g_end = '0;
    o.np = 0; o.busy = 0; o.glat = 0; o.rlat = 0; o.sa = '0; o.sl = '0;
    o.to = 0; o.hold = 1;
    n = 0;
    while (o_grant === 4'b0 && n < 20) begin @(negedge clk); n++; end
    o.glat = n;
    if (o_grant === 4'b0) begin o.to = 1; return; end
    o.g = o_grant; o.r = o_router; o.sa = o_addr; o.sl = o_len;
    n = 0;
    while (o_resetn !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    o.rlat = n;
    if (o_resetn !== 1'b1) begin o.to = 1; return; end
    while (o_resetn === 1'b1 && o.busy < 200) begin
      o.busy++;
      if (o_grant !== o.g || o_router !== o.g) o.hold = 0;
      if (lat != 0 && o.busy == lat) begin rd_done = !err || both; rd_err = err; rd_et = et; end
      @(negedge clk);
    end
    rd_done = 1'b0; rd_err = 1'b0;
    if (o_resetn === 1'b1) begin o.to = 1; return; end
    o.pd = o_done; o.pe = o_error;
    if (|(o_done | o_error)) o.np++;
    @(negedge clk);
    if (|(o_done | o_error)) o.np++;
    o.pd |= o_done; o.pe |= o_error;
    o.g_end = o_grant;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; rd_done = 1'b0; rd_err = 1'b0; rd_et = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_ptr = 0; m_etype = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; addr = '0; len = '0; rd_done = 1'b0; rd_err = 1'b0; rd_et = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (o_grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
    n_cmp++; if (o_router !== 4'b0) begin n_bad++; $display("FAIL reset_router: got %b want 0000", o_router); end
    n_cmp++; if ({o_done, o_error} !== 8'b0) begin n_bad++; $display("FAIL reset_pulses: got %b want 0", {o_done, o_error}); end
    n_cmp++; if (o_et !== 3'b000) begin n_bad++; $display("FAIL reset_etype: got %b want 000", o_et); end
    n_cmp++; if (o_resetn !== 1'b0) begin n_bad++; $display("FAIL reset_resetn: got %b want 0", o_resetn); end
    n_cmp++; if ({o_addr, o_len} !== '0) begin n_bad++; $display("FAIL reset_slots: got %h want 0", {o_addr, o_len}); end
    rst = 1'b0; m_ptr = 0; m_etype = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_single();
    obs_t o;
    logic [3:0][31:0] ea, el;
    for (int s = 0; s < 4; s++) begin addr[s] = $urandom & ~32'h3; len[s] = $urandom_range(1, 4096); end
    addr[1] = 32'h1000; len[1] = 32'd16;
    ea = '0; ea[1] = 32'h1000; el = '0; el[1] = 32'd16;
    req = 4'b0010;
    serve(20, 0, 0, 3'b000, o);
    req = '0;
    m_ptr = 2;
    n_cmp++; if (o.to !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got %0d want 0", o.to); end
    n_cmp++; if (o.glat != 1) begin n_bad++; $display("FAIL single_grant_latency: got %0d want 1", o.glat); end
    n_cmp++; if (o.rlat != 1) begin n_bad++; $display("FAIL single_resetn_latency: got %0d want 1", o.rlat); end
    n_cmp++; if (o.g !== 4'b0010 || o.r !== 4'b0010) begin n_bad++; $display("FAIL single_grant_router: got %b/%b want 0010/0010", o.g, o.r); end
    n_cmp++; if (o.sa !== ea || o.sl !== el) begin n_bad++; $display("FAIL single_slots: got %h/%h want %h/%h", o.sa, o.sl, ea, el); end
    n_cmp++; if (o.busy != 20 || !o.hold) begin n_bad++; $display("FAIL single_busy: got %0d hold %0d want 20 hold 1", o.busy, o.hold); end
    n_cmp++; if (o.pd !== 4'b0010 || o.pe !== 4'b0 || o.np != 1) begin n_bad++; $display("FAIL single_done: got %b/%b n=%0d want 0010/0000 n=1", o.pd, o.pe, o.np); end
    n_cmp++; if (o.g_end !== 4'b0 || o_resetn !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b/%b want 0000/0", o.g_end, o_resetn); end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    int exp_seq[5];
    int njobs;
`ifdef PAINTERENGINE_GPU_READER_ARBITER_RR_EN
    exp_seq = '{0, 1, 2, 3, 0}; njobs = 5;
`else
    exp_seq = '{0, 0, 0, 0, 0}; njobs = 3;
`endif
    apply_reset();
    req = 4'b1111;
    for (int j = 0; j < njobs; j++) begin
      serve(1, 0, 0, 3'b000, o);
      m_ptr = (model_winner(4'b1111, m_ptr) + 1) % 4;
      n_cmp++; if (o.g !== (4'b0001 << exp_seq[j]) || o.pd !== o.g) begin n_bad++; $display("FAIL simul_job%0d: got %b done %b want %b", j, o.g, o.pd, 4'b0001 << exp_seq[j]); end
      if (j > 0) begin
        n_cmp++; if (o.glat != 1) begin n_bad++; $display("FAIL simul_b2b_latency%0d: got %0d want 1", j, o.glat); end
      end
    end
    req = '0;
  endtask

  task automatic test_error();
    obs_t o;
    req = 4'b0100;
    serve(3, 1, 0, 3'b010, o);
    req = '0; m_ptr = 3; m_etype = 3'b010;
    n_cmp++; if (o.pe !== 4'b0100 || o.pd !== 4'b0 || o.np != 1) begin n_bad++; $display("FAIL error_pulse: got %b/%b n=%0d want 0100/0000 n=1", o.pe, o.pd, o.np); end
    n_cmp++; if (o_et !== 3'b010) begin n_bad++; $display("FAIL error_type: got %b want 010", o_et); end
    req = 4'b0001;
    serve(5, 0, 0, 3'b111, o);
    req = '0; m_ptr = 1;
    n_cmp++; if (o.pd !== 4'b0001 || o.pe !== 4'b0) begin n_bad++; $display("FAIL error_next_done: got %b/%b want 0001/0000", o.pd, o.pe); end
    n_cmp++; if (o_et !== 3'b010) begin n_bad++; $display("FAIL error_type_hold: got %b want 010", o_et); end
  endtask

  task automatic test_both();
    obs_t o;
    req = 4'b1000;
    serve(4, 1, 1, 3'b101, o);
    req = '0; m_ptr = 0; m_etype = 3'b101;
    n_cmp++; if (o.pe !== 4'b1000 || o.pd !== 4'b0 || o.np != 1) begin n_bad++; $display("FAIL both_pulse: got err %b done %b want 1000/0000", o.pe, o.pd); end
    n_cmp++; if (o_et !== 3'b101) begin n_bad++; $display("FAIL both_type: got %b want 101", o_et); end
  endtask

  task automatic test_watchdog();
    obs_t o;
    req = 4'b0010;
    serve(0, 0, 0, 3'b000, o);
    req = '0; m_ptr = 2; m_etype = 3'b110;
    n_cmp++; if (o.to !== 1'b0 || o.busy != 32) begin n_bad++; $display("FAIL wdog_busy: got %0d to %0d want 32", o.busy, o.to); end
    n_cmp++; if (o.pe !== 4'b0010 || o.pd !== 4'b0) begin n_bad++; $display("FAIL wdog_pulse: got %b/%b want 0010/0000", o.pe, o.pd); end
    n_cmp++; if (o_et !== 3'b110 || o_resetn !== 1'b0) begin n_bad++; $display("FAIL wdog_type: got %b resetn %b want 110/0", o_et, o_resetn); end
  endtask

  task automatic test_random();
    obs_t o;
    int w, lat, mode;
    logic [2:0] et;
    logic [3:0] r, eg;
    logic [3:0][31:0] ea, el;
    for (int j = 0; j < 12; j++) begin
      r = 4'($urandom_range(1, 15));
      for (int s = 0; s < 4; s++) begin addr[s] = $urandom & ~32'h3; len[s] = $urandom_range(1, 65535); end
      lat = $urandom_range(1, 25); mode = $urandom_range(0, 3); et = 3'($urandom);
      w = model_winner(r, m_ptr);
      eg = 4'b0001 << w;
      ea = '0; ea[w] = addr[w]; el = '0; el[w] = len[w];
      req = r;
      serve(lat, mode >= 2, mode == 3, et, o);
      req = '0;
      m_ptr = (w + 1) % 4;
      if (mode >= 2) m_etype = et;
      n_cmp++; if (o.to !== 1'b0 || o.g !== eg || o.busy != lat) begin n_bad++; $display("FAIL rand%0d_grant: got %b busy %0d want %b busy %0d", j, o.g, o.busy, eg, lat); end
      n_cmp++; if (o.sa !== ea || o.sl !== el) begin n_bad++; $display("FAIL rand%0d_slots: got %h/%h want %h/%h", j, o.sa, o.sl, ea, el); end
      n_cmp++; if (o.pd !== ((mode < 2) ? eg : 4'b0) || o.pe !== ((mode >= 2) ? eg : 4'b0) || o.np != 1) begin n_bad++; $display("FAIL rand%0d_pulse: got %b/%b n=%0d mode %0d", j, o.pd, o.pe, o.np, mode); end
      n_cmp++; if (o_et !== m_etype) begin n_bad++; $display("FAIL rand%0d_etype: got %b want %b", j, o_et, m_etype); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int n, pulses;
    req = 4'b0001;
    n = 0;
    while (o_resetn !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n_cmp++; if (o_resetn !== 1'b1) begin n_bad++; $display("FAIL rmid_start: got resetn %b want 1", o_resetn); end
    repeat (5) @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    n_cmp++; if ({o_grant, o_router, o_done, o_error, o_et, o_resetn} !== 20'b0) begin n_bad++; $display("FAIL rmid_outputs: got %b want 0", {o_grant, o_router, o_done, o_error, o_et, o_resetn}); end
    n_cmp++; if ({o_addr, o_len} !== '0) begin n_bad++; $display("FAIL rmid_slots: got %h want 0", {o_addr, o_len}); end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (|(o_done | o_error)) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL rmid_nopulse: got %0d want 0", pulses); end
    rst = 1'b0; m_ptr = 0; m_etype = 3'b000;
    req = 4'b1001;
    serve(6, 0, 0, 3'b000, o);
    req = '0;
    n_cmp++; if (o.g !== (4'b0001 << model_winner(4'b1001, 0)) || o.pd !== o.g) begin n_bad++; $display("FAIL rmid_after: got %b done %b want 0001", o.g, o.pd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_error();
    test_both();
    test_watchdog();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
